// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared VRAM geometry and arbiter state encoding
//
// Shared with the video scanout block.
//   VRAM_ADDR_W : word-address width (addresses are [VRAM_ADDR_W:1])
//   VRAM_DATA_W : word width, byte lanes [15:8] upper, [7:0] lower
//   arb_state_t : IDLE / ACCESS / DONE for vram_arbiter
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - combinational winner selection for the VRAM arbiter
//
// Ports:
//   req0, req1   in   pending requests (0 = CPU, 1 = loader DMA)
//   last_winner  in   requester granted last (used only with VRAM_ARB_RR_EN)
//   grant_valid  out  at least one request pending
//   grant_id     out  requester that wins this cycle
//
// Macro VRAM_ARB_RR_EN: round-robin on simultaneous requests; otherwise
// requester 0 has fixed priority.
module vram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req0 | req1;

`ifdef VRAM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    assign grant_id = (req0 & req1) ? ~last_winner : req1;
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
    assign grant_id = ~req0 & req1;
`endif

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-master arbiter for the VRAM read/write port
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   req/we/addr/din/ub/lb{0,1}       requester fields, held until own ack
//   ack{0,1}, dout{0,1}              one-cycle ack, read data held to next ack
//   mem_we/mem_addr/mem_din/mem_ub/mem_lb  registered VRAM port outputs
//   mem_dout                         VRAM registered read data
//   owner, busy                      granted requester, access in progress
//
// Macro VRAM_ARB_RR_EN: round-robin arbitration with a last-winner register;
// undefined gives fixed priority to requester 0.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W:1]   addr0,
    input  logic [ADDR_W:1]   addr1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              ub0,
    input  logic              ub1,
    input  logic              lb0,
    input  logic              lb1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic              mem_we,
    output logic [ADDR_W:1]   mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_ub,
    output logic              mem_lb,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              owner,
    output logic              busy
);

    arb_state_t state;
    logic       grant_valid;
    logic       grant_id;
    logic       last_winner;

`ifndef VRAM_ARB_RR_EN
    assign last_winner = 1'b0;
`endif

    vram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_winner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_ub   <= 1'b0;
            mem_lb   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            dout0    <= '0;
            dout1    <= '0;
            owner    <= 1'b0;
            busy     <= 1'b0;
`ifdef VRAM_ARB_RR_EN
            // Reset to 1 so requester 0 wins the first tie.
            last_winner <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_id;
                        busy  <= 1'b1;
                        state <= ACCESS;
`ifdef VRAM_ARB_RR_EN
                        last_winner <= grant_id;
`endif
                        if (grant_id) begin
                            mem_we   <= we1;
                            mem_addr <= addr1;
                            mem_din  <= din1;
                            mem_ub   <= ub1;
                            mem_lb   <= lb1;
                        end else begin
                            mem_we   <= we0;
                            mem_addr <= addr0;
                            mem_din  <= din0;
                            mem_ub   <= ub0;
                            mem_lb   <= lb0;
                        end
                    end
                end
                ACCESS: begin
                    // RAM samples the port this cycle; a write lasts one clock.
                    mem_we <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    // Writes also return the old word (read-before-write RAM).
                    if (owner) begin
                        dout1 <= mem_dout;
                        ack1  <= 1'b1;
                    end else begin
                        dout0 <= mem_dout;
                        ack0  <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW = VRAM_ADDR_W;
    localparam int DW = VRAM_DATA_W;

    typedef struct {
        logic          we;
        logic [AW:1]   addr;
        logic [DW-1:0] din;
        logic          ub;
        logic          lb;
    } txn_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW:1]   addr0 = '0, addr1 = '0;
    logic [DW-1:0] din0 = '0, din1 = '0;
    logic          ub0 = 1'b0, ub1 = 1'b0, lb0 = 1'b0, lb1 = 1'b0;
    logic          ack0, ack1, mem_we, mem_ub, mem_lb, owner, busy;
    logic [DW-1:0] dout0, dout1, mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [AW:1]   mem_addr;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .ub0(ub0), .ub1(ub1), .lb0(lb0), .lb1(lb1),
        .ack0(ack0), .ack1(ack1), .dout0(dout0), .dout1(dout1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ub(mem_ub), .mem_lb(mem_lb), .mem_dout(mem_dout),
        .owner(owner), .busy(busy)
    );

    // Registered-read, read-before-write VRAM port.
    always @(posedge clk) begin
        mem_dout <= ram[mem_addr];
        if (mem_we) begin
            if (mem_ub) ram[mem_addr][15:8] <= mem_din[15:8];
            if (mem_lb) ram[mem_addr][7:0]  <= mem_din[7:0];
        end
    end

    int tests = 0, fails = 0;
    int cyc = 0, left = 0, we_cycles = 0, raise_pct = 100;
    logic win = 1'b0, last = 1'b1, done_now = 1'b0;
    txn_t cur;
    logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;
    txn_t q0[$], q1[$];
    int ack_ids[$], ack_cycs[$], grant_cycs[$];
    logic [DW-1:0] ack_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ack_ids.delete(); ack_cycs.delete(); grant_cycs.delete(); ack_data.delete();
    endtask

    task automatic push(input int id, input logic we, input logic [AW:1] a,
                        input logic [DW-1:0] d, input logic ub, input logic lb);
        txn_t t;
        t.we = we; t.addr = a; t.din = d; t.ub = ub; t.lb = lb;
        if (id == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    // One clock: reference model at the rising edge, checks and requester
    // drivers at the falling edge.
    task automatic tick();
        logic r0, r1;
        logic [DW-1:0] old;
        txn_t t;
        @(posedge clk);
        cyc++;
        r0 = req0; r1 = req1; done_now = 1'b0;
        if (left == 0) begin
            if (r0 | r1) begin
                if (r0 & r1) begin
`ifdef VRAM_ARB_RR_EN
                    win = ~last;
`else
                    win = 1'b0;
`endif
                end else begin
                    win = r1;
                end
                last = win;
                if (win) begin
                    cur.we = we1; cur.addr = addr1; cur.din = din1; cur.ub = ub1; cur.lb = lb1;
                end else begin
                    cur.we = we0; cur.addr = addr0; cur.din = din0; cur.ub = ub0; cur.lb = lb0;
                end
                grant_cycs.push_back(cyc);
                left = 2;
            end
        end else begin
            left--;
            if (left == 0) done_now = 1'b1;
        end
        @(negedge clk);
        if (mem_we === 1'b1) we_cycles++;
        chk("ack0", ack0, done_now && !win);
        chk("ack1", ack1, done_now && win);
        chk("busy", busy, left != 0);
        chk("mem_we", mem_we, (left == 2) && cur.we);
        if (left != 0) chk("owner", owner, win);
        if (left == 2) begin
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_din", mem_din, cur.din);
            chk("mem_be", {mem_ub, mem_lb}, {cur.ub, cur.lb});
        end
        if (done_now) begin
            old = ref_mem[cur.addr];
            if (win) exp_d1 = old; else exp_d0 = old;
            if (cur.we) begin
                if (cur.ub) ref_mem[cur.addr][15:8] = cur.din[15:8];
                if (cur.lb) ref_mem[cur.addr][7:0]  = cur.din[7:0];
            end
            ack_ids.push_back(int'(win));
            ack_cycs.push_back(cyc);
            ack_data.push_back(win ? dout1 : dout0);
            if (win) begin void'(q1.pop_front()); req1 = 1'b0; end
            else     begin void'(q0.pop_front()); req0 = 1'b0; end
        end
        chk("dout0", dout0, exp_d0);
        chk("dout1", dout1, exp_d1);
        if (!req0 && q0.size() > 0 && $urandom_range(99) < raise_pct) begin
            t = q0[0];
            req0 = 1'b1; we0 = t.we; addr0 = t.addr; din0 = t.din; ub0 = t.ub; lb0 = t.lb;
        end
        if (!req1 && q1.size() > 0 && $urandom_range(99) < raise_pct) begin
            t = q1[0];
            req1 = 1'b1; we1 = t.we; addr1 = t.addr; din1 = t.din; ub1 = t.ub; lb1 = t.lb;
        end
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 || left != 0) && n < max) begin
            tick();
            n++;
        end
        chk("run_done", (q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && left == 0), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, {ack0, ack1}, 0);
        chk({tag, "_dout0"}, dout0, 0);
        chk({tag, "_dout1"}, dout1, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din"}, mem_din, 0);
        chk({tag, "_mem_be"}, {mem_ub, mem_lb}, 0);
        chk({tag, "_owner_busy"}, {owner, busy}, 0);
    endtask

    int exp3[4];
    int exp4[5];
    int wb;
    logic [DW-1:0] rd;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 16'($urandom);
            ref_mem[i] = ram[i];
        end

        // Reset state
        #2 resetn = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        tick(); tick();

        // Single read
        ram[14'h0100] = 16'hBEEF; ref_mem[14'h0100] = 16'hBEEF;
        clear_logs(); wb = we_cycles;
        push(0, 1'b0, 14'h0100, 16'h0000, 1'b0, 1'b0);
        run_idle(20);
        chk("read_acks", ack_ids.size(), 1);
        chk("read_latency", ack_cycs[0] - grant_cycs[0], 2);
        chk("read_dout0", dout0, 16'hBEEF);
        chk("read_no_we", we_cycles - wb, 0);

        // Byte write on the lower lane
        ram[14'h3FFF] = 16'h5566; ref_mem[14'h3FFF] = 16'h5566;
        clear_logs(); wb = we_cycles;
        push(1, 1'b1, 14'h3FFF, 16'h12AB, 1'b0, 1'b1);
        run_idle(20);
        chk("bytewr_ram", ram[14'h3FFF], 16'h55AB);
        chk("bytewr_dout1", dout1, 16'h5566);
        chk("bytewr_we_cycles", we_cycles - wb, 1);

        // Simultaneous requests, two per requester
`ifdef VRAM_ARB_RR_EN
        exp3 = '{0, 1, 0, 1};
`else
        exp3 = '{0, 0, 1, 1};
`endif
        clear_logs();
        push(0, 1'b0, 14'h0010, 16'h0, 1'b0, 1'b0);
        push(0, 1'b0, 14'h0011, 16'h0, 1'b0, 1'b0);
        push(1, 1'b0, 14'h0020, 16'h0, 1'b0, 1'b0);
        push(1, 1'b0, 14'h0021, 16'h0, 1'b0, 1'b0);
        run_idle(40);
        chk("simul_count", ack_ids.size(), 4);
        for (int i = 0; i < 4; i++) chk("simul_order", ack_ids[i], exp3[i]);
        for (int i = 0; i < 3; i++) chk("simul_spacing", ack_cycs[i+1] - ack_cycs[i], 3);

        // Starvation: requester 0 keeps asking for four accesses
`ifdef VRAM_ARB_RR_EN
        exp4 = '{0, 1, 0, 0, 0};
`else
        exp4 = '{0, 0, 0, 0, 1};
`endif
        clear_logs();
        for (int i = 0; i < 4; i++) push(0, 1'b0, 14'(40 + i), 16'h0, 1'b0, 1'b0);
        push(1, 1'b0, 14'h0050, 16'h0, 1'b0, 1'b0);
        run_idle(50);
        chk("starve_count", ack_ids.size(), 5);
        for (int i = 0; i < 5; i++) chk("starve_order", ack_ids[i], exp4[i]);
        chk("starve_last_gap", ack_cycs[4] - ack_cycs[3], 3);

        // Back-to-back reads
        ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333;
        clear_logs();
        for (int i = 0; i < 3; i++) push(0, 1'b0, 14'(i), 16'h0, 1'b0, 1'b0);
        run_idle(40);
        chk("b2b_count", ack_ids.size(), 3);
        for (int i = 0; i < 3; i++) chk("b2b_id", ack_ids[i], 0);
        chk("b2b_d0", ack_data[0], 16'h1111);
        chk("b2b_d1", ack_data[1], 16'h2222);
        chk("b2b_d2", ack_data[2], 16'h3333);
        chk("b2b_gap0", ack_cycs[1] - ack_cycs[0], 3);
        chk("b2b_gap1", ack_cycs[2] - ack_cycs[1], 3);

        // Reset during ACCESS of a read
        clear_logs();
        push(0, 1'b0, 14'h0100, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid_in_access", left, 2);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        left = 0; last = 1'b1; exp_d0 = '0; exp_d1 = '0;
        q0.delete(); req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        resetn = 1'b1;
        tick(); tick(); tick();
        chk("midreset_no_ack", ack_ids.size(), 0);
        push(0, 1'b0, 14'h0100, 16'h0, 1'b0, 1'b0);
        run_idle(20);
        chk("midreset_reissue", ack_ids.size(), 1);
        chk("midreset_data", dout0, 16'hBEEF);

        // Randomized traffic on a small address window
        raise_pct = 60;
        for (int n = 0; n < 800; n++) begin
            if (q0.size() < 2 && $urandom_range(3) == 0)
                push(0, 1'($urandom), 14'($urandom_range(15)), 16'($urandom), 1'($urandom), 1'($urandom));
            if (q1.size() < 2 && $urandom_range(3) == 0)
                push(1, 1'($urandom), 14'($urandom_range(15)), 16'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        run_idle(200);
        for (int i = 0; i < 16; i++) begin
            rd = ram[i];
            chk("rand_ram", rd, ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
